gpioemu_cmd_sequencer: RTL and testbench
========================================

Name: gpioemu_cmd_sequencer

Overview:
Upstream bus master for the gpioemu multiply/popcount peripheral.
- Accepts operand pairs from a host through a valid/ready command FIFO.
- Runs the full register-access sequence on the peripheral's strobe bus: write A, write B, start, poll status, read product, read ones count.
- Returns each result on a valid/ready response port.
- Sits between the host/test driver and gpioemu. It is the only bus master on that register window.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
POLL_GAP, 4, idle clk cycles before each status read (>=1)
TIMEOUT, 64, max status reads per job before abort (>=1)
BASE, 16'h0380, peripheral register window base address

Ports:
clk  in  1  clock
n_reset  in  1  reset, asynchronous, active-low
cmd_valid  in  1  host offers operand pair
cmd_ready  out  1  FIFO not full
cmd_a  in  24  operand A
cmd_b  in  24  operand B
rsp_valid  out  1  result available
rsp_ready  in  1  host accepts result
rsp_product  out  32  low 32 bits of A*B, as read from peripheral
rsp_ones  out  6  popcount of product, from peripheral count register bits [5:0]
rsp_timeout  out  1  job aborted; product/ones are 0
busy  out  1  state != IDLE or FIFO not empty
job_count  out  16  completed jobs including timeouts, wraps at 16'hFFFF->0
bus_addr  out  16  peripheral saddress
bus_wr  out  1  peripheral swr strobe
bus_rd  out  1  peripheral srd strobe
bus_wdata  out  32  peripheral sdata_in
bus_rdata  in  32  peripheral sdata_out

Behaviour:
Reset (asynchronous, any time, including mid-access):
- All outputs go to 0, except cmd_ready=1.
- FIFO is emptied, state goes to IDLE, poll counter is cleared.
- Strobes drop immediately.

Command FIFO:
- A push happens on the clk edge where cmd_valid&&cmd_ready.
- cmd_ready = !full, registered-state derived. A pop does not raise cmd_ready in the same cycle.
- Push and pop in the same cycle are both honoured.

Bus access:
- Every access takes exactly 3 cycles: SETUP, STROBE, HOLD.
- bus_addr and bus_wdata are stable across all 3 cycles.
- The strobe (bus_wr or bus_rd) is high only in STROBE. Never both strobes high.
- Read data is captured from bus_rdata in HOLD.
- bus_wdata = 0 during reads.

States:
- IDLE: if FIFO is non-empty, pop the head into A_reg/B_reg and go to WR_A; otherwise stay.
- WR_A: write {8'h0,A_reg} to BASE+0x00.
- WR_B: write {8'h0,B_reg} to BASE+0x08.
- WR_GO: write 32'h1 to BASE+0x20. Clear the poll counter.
- WAIT: POLL_GAP cycles with strobes low, then RD_ST.
- RD_ST: read BASE+0x20 and increment the poll counter.
  - If rdata[1:0]==2'b11 -> RD_W.
  - Else if poll counter==TIMEOUT -> RSP with timeout=1, product=0, ones=0.
  - Else -> WAIT.
- RD_W: read BASE+0x10, latch the product.
- RD_L: read BASE+0x18, latch rdata[5:0] as ones.
- RSP: rsp_valid=1 with outputs held stable. On rsp_valid&&rsp_ready, increment job_count, drop rsp_valid and go to IDLE.

Latency:
- On first-poll success, rsp_valid rises exactly 19+POLL_GAP cycles after the pop edge.
- Each extra poll adds 3+POLL_GAP cycles.
- Back-to-back jobs: the next pop occurs in the IDLE cycle after the RSP handshake.

Width rules:
- Operands are zero-extended to 32 bits.
- rsp_ones is 6 bits, range 0..32.
- rsp_product is taken verbatim from the peripheral. Overflow beyond 32 bits is not flagged.

No new bus access starts while in RSP, regardless of FIFO contents.

Test Plan:
- Push (3,5) with the real gpioemu attached, rsp_ready=1:
  - bus trace is wr 0x380=3, wr 0x388=5, wr 0x3A0=1, rd 0x3A0, then rd 0x390/0x398 after status reads 2'b11;
  - rsp_product=15, rsp_ones=4, rsp_timeout=0, job_count=1.
- Push (0xFFFFFF,0xFFFFFF) -> rsp_product=0xFE000001, rsp_ones=8.
- Hold rsp_ready=0 for 20 cycles after rsp_valid:
  - outputs stay stable;
  - no bus strobes occur;
  - FIFO keeps accepting pushes until 4 entries are held, then cmd_ready=0.
- Push 5 commands back-to-back with the FIFO idle-blocked:
  - the 5th stalls until the first pop;
  - all 5 responses return in order with correct products.
- Bus model whose status is stuck at 2'b01 -> exactly 64 RD_ST accesses, then rsp_timeout=1, product=0, ones=0; the next job proceeds normally.
- Assert n_reset low during the STROBE of WR_B:
  - bus_wr drops immediately; all outputs reset; cmd_ready=1;
  - after release, a new push (2,2) yields product 4, ones 1.

Source files
------------

// File: rtl/gpioemu_cmd_sequencer.sv
// gpioemu_cmd_sequencer
// Bus master for the gpioemu multiply/popcount peripheral. Operand pairs are
// queued in a small command FIFO. For each job the sequencer writes A, writes B,
// starts the peripheral, polls status, then reads the product and the ones
// count. The result is returned on a valid/ready response port.
//
// Ports:
//   clk, n_reset                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (cmd_a, cmd_b operands)
//   rsp_valid/rsp_ready          response handshake
//   rsp_product/ones/timeout     result fields, held while rsp_valid
//   busy                         job in progress or FIFO not empty
//   job_count                    completed jobs (including timeouts), wrapping
//   bus_addr/wr/rd/wdata/rdata   peripheral strobe bus
module gpioemu_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned POLL_GAP   = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [15:0] BASE       = 16'h0380
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a,
    input  logic [23:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_product,
    output logic [5:0]  rsp_ones,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] job_count,
    output logic [15:0] bus_addr,
    output logic        bus_wr,
    output logic        bus_rd,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DepthCnt = FIFO_DEPTH[PW:0];
    localparam logic [15:0] GapLast  = 16'(POLL_GAP - 1);
    localparam logic [15:0] PollMax  = 16'(TIMEOUT);

    localparam logic [1:0] PhSetup  = 2'd0;
    localparam logic [1:0] PhStrobe = 2'd1;
    localparam logic [1:0] PhHold   = 2'd2;

    typedef enum logic [3:0] {
        StIdle, StWrA, StWrB, StWrGo, StWait, StRdSt, StRdW, StRdL, StRsp
    } state_t;

    // ---------------- command FIFO ----------------
    logic [47:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push, pop;

    assign cmd_ready = (count_q != DepthCnt);
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- sequencer state ----------------
    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] poll_q, poll_d;
    logic [23:0] a_q, a_d, b_q, b_d;
    logic [31:0] prod_q, prod_d;
    logic [5:0]  ones_q, ones_d;
    logic        tmo_q, tmo_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] job_q, job_d;

    // Access decode: address offset, direction and write data per access state.
    logic        acc_wr, acc_rd, in_access, acc_done;
    logic [7:0]  acc_off;
    logic [31:0] acc_data;

    always_comb begin
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        acc_off  = 8'h00;
        acc_data = 32'h0;
        case (state_q)
            StWrA:   begin acc_wr = 1'b1; acc_off = 8'h00; acc_data = {8'h00, a_q}; end
            StWrB:   begin acc_wr = 1'b1; acc_off = 8'h08; acc_data = {8'h00, b_q}; end
            StWrGo:  begin acc_wr = 1'b1; acc_off = 8'h20; acc_data = 32'h1;        end
            StRdSt:  begin acc_rd = 1'b1; acc_off = 8'h20; end
            StRdW:   begin acc_rd = 1'b1; acc_off = 8'h10; end
            StRdL:   begin acc_rd = 1'b1; acc_off = 8'h18; end
            default: ;
        endcase
    end

    assign in_access = acc_wr || acc_rd;
    assign acc_done  = in_access && (phase_q == PhHold);

    assign bus_addr  = in_access ? (BASE + {8'h00, acc_off}) : 16'h0000;
    assign bus_wdata = acc_data;
    assign bus_wr    = acc_wr && (phase_q == PhStrobe);
    assign bus_rd    = acc_rd && (phase_q == PhStrobe);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        poll_d  = poll_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        ones_d  = ones_q;
        tmo_d   = tmo_q;
        job_d   = job_q;
        pop     = 1'b0;

        if (in_access) begin
            phase_d = acc_done ? PhSetup : phase_q + 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    a_d     = mem[rd_ptr_q][47:24];
                    b_d     = mem[rd_ptr_q][23:0];
                    prod_d  = 32'h0;
                    ones_d  = 6'h0;
                    tmo_d   = 1'b0;
                    state_d = StWrA;
                end
            end
            StWrA: if (acc_done) state_d = StWrB;
            StWrB: if (acc_done) state_d = StWrGo;
            StWrGo: begin
                poll_d = 16'h0;
                if (acc_done) begin
                    gap_d   = 16'h0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (gap_q == GapLast) begin
                    gap_d   = 16'h0;
                    state_d = StRdSt;
                end else begin
                    gap_d = gap_q + 16'h1;
                end
            end
            StRdSt: begin
                if (acc_done) begin
                    poll_d = poll_q + 16'h1;
                    // Done wins over timeout even on the last permitted poll.
                    if (bus_rdata[1:0] == 2'b11) begin
                        state_d = StRdW;
                    end else if (poll_q + 16'h1 == PollMax) begin
                        tmo_d   = 1'b1;
                        prod_d  = 32'h0;
                        ones_d  = 6'h0;
                        state_d = StRsp;
                    end else begin
                        gap_d   = 16'h0;
                        state_d = StWait;
                    end
                end
            end
            StRdW: begin
                if (acc_done) begin
                    prod_d  = bus_rdata;
                    state_d = StRdL;
                end
            end
            StRdL: begin
                if (acc_done) begin
                    ones_d  = bus_rdata[5:0];
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_valid_q && rsp_ready) begin
                    job_d   = job_q + 16'h1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // rsp_valid follows entry into StRsp by one cycle and drops on the handshake.
        rsp_valid_d = (state_q == StRsp) && !(rsp_valid_q && rsp_ready);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            phase_q     <= PhSetup;
            gap_q       <= 16'h0;
            poll_q      <= 16'h0;
            a_q         <= 24'h0;
            b_q         <= 24'h0;
            prod_q      <= 32'h0;
            ones_q      <= 6'h0;
            tmo_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            job_q       <= 16'h0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            gap_q       <= gap_d;
            poll_q      <= poll_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            ones_q      <= ones_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            job_q       <= job_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = prod_q;
    assign rsp_ones    = ones_q;
    assign rsp_timeout = tmo_q;
    assign job_count   = job_q;
    assign busy        = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_gpioemu_cmd_sequencer.sv
// tb_gpioemu_cmd_sequencer
// Self-checking bench for gpioemu_cmd_sequencer. A behavioural peripheral model
// answers the strobe bus. A job scoreboard predicts responses, FIFO occupancy,
// job count, latency and the bus access order. Directed jobs pin literal
// results, and a randomized phase exercises random operands and backpressure.
module tb_gpioemu_cmd_sequencer;

    localparam int          PG   = 4;
    localparam int          TO   = 64;
    localparam int          DEP  = 4;
    localparam logic [15:0] BASE = 16'h0380;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_valid, cmd_ready;
    logic [23:0] cmd_a, cmd_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_product;
    logic [5:0]  rsp_ones;
    logic        rsp_timeout, busy;
    logic [15:0] job_count, bus_addr;
    logic        bus_wr, bus_rd;
    logic [31:0] bus_wdata, bus_rdata;

    gpioemu_cmd_sequencer #(
        .FIFO_DEPTH(DEP), .POLL_GAP(PG), .TIMEOUT(TO), .BASE(BASE)
    ) dut (
        .clk(clk), .n_reset(n_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
        .rsp_ones(rsp_ones), .rsp_timeout(rsp_timeout), .busy(busy),
        .job_count(job_count), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- job scoreboard ----------------
    typedef struct {
        logic [23:0] a, b;
        logic [31:0] prod;
        logic [5:0]  ones;
        logic        tmo;
        int          extra;
    } job_t;

    job_t        exp_q[$];
    job_t        cur, ent;
    int          occ = 0;
    bit          active = 0;
    logic [15:0] exp_jobs = 0;
    int          cyc = 0, start_cyc = 0, stat_reads = 0, done_cnt = 0;
    int          next_extra = 0;
    bit          next_stuck = 0;
    logic [47:0] full48;

    // ---------------- peripheral model ----------------
    logic [23:0] pa = 0, pb = 0;
    logic [31:0] pprod = 0;
    logic [5:0]  pones = 0;
    logic [1:0]  pstat = 2'b00;
    int          polls_left = 0;
    bit          pstuck = 0;
    int          acc_step = 0;

    always_comb begin
        case (bus_addr)
            BASE + 16'h10: bus_rdata = pprod;
            BASE + 16'h18: bus_rdata = {26'h2AAAAAA, pones};
            BASE + 16'h20: bus_rdata = {30'h15555555, pstat};
            default:       bus_rdata = 32'hDEADBEEF;
        endcase
    end

    logic [15:0] prev_addr = 0, hold_addr = 0;
    logic [31:0] prev_wdata = 0, hold_wdata = 0;
    logic [1:0]  prev_strobe = 0;
    bit          prev_rv = 0, hold_pend = 0;

    task automatic do_access();
        cur = exp_q[0];
        case (acc_step)
            0: begin
                check("bus_wr_a", {bus_wr, bus_rd, bus_addr, bus_wdata},
                      {2'b10, BASE, 8'h00, cur.a});
                pa = bus_wdata[23:0];
                acc_step = 1;
            end
            1: begin
                check("bus_wr_b", {bus_wr, bus_rd, bus_addr, bus_wdata},
                      {2'b10, BASE + 16'h08, 8'h00, cur.b});
                pb = bus_wdata[23:0];
                acc_step = 2;
            end
            2: begin
                check("bus_wr_go", {bus_wr, bus_rd, bus_addr, bus_wdata},
                      {2'b10, BASE + 16'h20, 32'h1});
                full48 = {24'h0, pa} * {24'h0, pb};
                pprod = full48[31:0];
                pones = 6'($countones(full48[31:0]));
                polls_left = cur.extra;
                pstuck = cur.tmo;
                acc_step = 3;
            end
            3: begin
                check("bus_rd_status", {bus_wr, bus_rd, bus_addr, bus_wdata},
                      {2'b01, BASE + 16'h20, 32'h0});
                stat_reads++;
                if (!pstuck && polls_left == 0) begin
                    pstat = 2'b11;
                    acc_step = 4;
                end else begin
                    pstat = 2'b01;
                    if (polls_left > 0) polls_left--;
                end
            end
            4: begin
                check("bus_rd_product", {bus_wr, bus_rd, bus_addr, bus_wdata},
                      {2'b01, BASE + 16'h10, 32'h0});
                acc_step = 5;
            end
            5: begin
                check("bus_rd_ones", {bus_wr, bus_rd, bus_addr, bus_wdata},
                      {2'b01, BASE + 16'h18, 32'h0});
                acc_step = 6;
            end
            default: check("bus_extra_access", {bus_wr, bus_rd, bus_addr}, 0);
        endcase
    endtask

    // One compare process: all checks and model updates happen away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!n_reset) begin
            check("reset_outputs",
                  {rsp_valid, rsp_product, rsp_ones, rsp_timeout, busy, job_count,
                   bus_addr, bus_wr, bus_rd, bus_wdata, cmd_ready}, 1);
            exp_q.delete();
            occ = 0; active = 0; exp_jobs = 0; acc_step = 0; stat_reads = 0;
            hold_pend = 0; prev_addr = 0; prev_wdata = 0; prev_strobe = 0; prev_rv = 0;
        end else begin
            // A job starts when the address first moves onto the A register.
            if (bus_addr == BASE && prev_addr != BASE) begin
                occ--;
                active = 1;
                start_cyc = cyc;
                acc_step = 0;
                stat_reads = 0;
            end
            check("cmd_ready", cmd_ready, occ < DEP);
            check("busy", busy, (occ > 0) || active);
            check("job_count", job_count, exp_jobs);
            check("strobe_excl", bus_wr && bus_rd, 0);

            if (hold_pend) begin
                check("bus_hold", {bus_addr, bus_wdata, bus_wr, bus_rd},
                      {hold_addr, hold_wdata, 2'b00});
                hold_pend = 0;
            end
            if (bus_wr || bus_rd) begin
                check("bus_setup", {prev_addr, prev_wdata, prev_strobe},
                      {bus_addr, bus_wdata, 2'b00});
                if (exp_q.size() == 0) check("bus_access_no_job", {bus_wr, bus_rd}, 0);
                else do_access();
                hold_pend = 1;
                hold_addr = bus_addr;
                hold_wdata = bus_wdata;
            end

            if (rsp_valid) begin
                check("rsp_bus_quiet", {bus_wr, bus_rd, bus_addr}, 0);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    cur = exp_q[0];
                    check("rsp_fields", {rsp_product, rsp_ones, rsp_timeout},
                          {cur.prod, cur.ones, cur.tmo});
                    if (!prev_rv) begin
                        check("rsp_latency", cyc - start_cyc,
                              cur.tmo ? (13 + PG + (3 + PG) * (TO - 1))
                                      : (19 + PG + (3 + PG) * cur.extra));
                        check("status_reads", stat_reads, cur.tmo ? TO : cur.extra + 1);
                    end
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        exp_jobs++;
                        active = 0;
                        done_cnt++;
                    end
                end
            end

            if (cmd_valid && cmd_ready) begin
                full48 = {24'h0, cmd_a} * {24'h0, cmd_b};
                ent.a = cmd_a;
                ent.b = cmd_b;
                ent.tmo = next_stuck;
                ent.prod = next_stuck ? 32'h0 : full48[31:0];
                ent.ones = next_stuck ? 6'h0 : 6'($countones(full48[31:0]));
                ent.extra = next_extra;
                exp_q.push_back(ent);
                occ++;
            end
            prev_addr = bus_addr;
            prev_wdata = bus_wdata;
            prev_strobe = {bus_wr, bus_rd};
            prev_rv = rsp_valid;
        end
    end

    // ---------------- stimulus helpers (called at posedge+2) ----------------
    task automatic push(input logic [23:0] a, input logic [23:0] b);
        int n = 0;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 2000);
        check("push_accepted", cmd_ready, 1);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 3000);
        check("wait_rsp_valid", rsp_valid, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 20000);
        check("drain_busy", busy, 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    task automatic run_directed(input logic [23:0] a, input logic [23:0] b,
                                input logic [31:0] p, input logic [5:0] o, input string tag);
        next_extra = 0;
        next_stuck = 0;
        push(a, b);
        wait_rsp();
        check({tag, "_product"}, rsp_product, p);
        check({tag, "_ones"}, rsp_ones, o);
        check({tag, "_timeout"}, rsp_timeout, 0);
        @(posedge clk);
        #2;
    endtask

    bit stop = 0;

    initial begin
        n_reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = 24'h0;
        cmd_b = 24'h0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_reset = 1'b1;

        run_directed(24'd3, 24'd5, 32'd15, 6'd4, "job_3x5");
        check("job_count_first", job_count, 16'd1);
        run_directed(24'hFFFFFF, 24'hFFFFFF, 32'hFE000001, 6'd8, "job_max");

        // Response held off for 20 cycles while the FIFO fills.
        rsp_ready = 1'b0;
        next_extra = 1;
        push(24'd10, 24'd20);
        wait_rsp();
        @(posedge clk);
        #2;
        fork
            begin
                repeat (20) @(posedge clk);
                #2;
                rsp_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    next_extra = i % 3;
                    push(24'(i + 1), 24'(1000 + i));
                    if (i == 3) begin
                        @(negedge clk);
                        check("fifo_full_ready", cmd_ready, 0);
                        check("held_rsp_valid", rsp_valid, 1);
                        @(posedge clk);
                        #2;
                    end
                end
            end
        join
        wait_drain();
        @(posedge clk);
        #2;

        // Stuck status: the job must time out after exactly TO polls.
        next_stuck = 1;
        next_extra = 0;
        push(24'd6, 24'd7);
        wait_rsp();
        check("stuck_timeout", rsp_timeout, 1);
        check("stuck_product", rsp_product, 0);
        check("stuck_ones", rsp_ones, 0);
        check("stuck_status_reads", stat_reads, 64);
        @(posedge clk);
        #2;
        next_stuck = 0;
        run_directed(24'd11, 24'd13, 32'd143, 6'd5, "after_timeout");

        // Reset asserted in the middle of the WR_B strobe.
        next_extra = 0;
        push(24'd7, 24'd9);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(bus_wr && bus_addr == BASE + 16'h08) && n < 200);
            check("saw_wr_b_strobe", bus_wr, 1);
        end
        #1;
        n_reset = 1'b0;
        #1;
        check("async_reset_outputs",
              {rsp_valid, rsp_product, rsp_ones, rsp_timeout, busy, job_count,
               bus_addr, bus_wr, bus_rd, bus_wdata, cmd_ready}, 1);
        repeat (2) @(posedge clk);
        #2;
        n_reset = 1'b1;
        run_directed(24'd2, 24'd2, 32'd4, 6'd1, "after_reset");

        // Randomized jobs with random gaps, poll counts and backpressure.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #2;
                    end
                    next_extra = $urandom_range(0, 2);
                    push(24'($urandom()), 24'($urandom()));
                end
                wait_drain();
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #2;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        check("random_jobs_done", done_cnt >= 38, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
